// File: rtl/dsp_add_v2_packer.sv
// Packs pairs of operand pairs into the two lanes of dsp_add_v2.
// Optional idle auto-flush of a half pair is built only with `define PACKER_TIMEOUT_EN.
module dsp_add_v2_packer #(
    parameter int unsigned width   = 24,
    parameter int unsigned timeout = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_a,
    input  logic [width-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] a0,
    output logic [width-1:0] b0,
    output logic [width-1:0] a1,
    output logic [width-1:0] b1,
    output logic             lane1_valid
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic   accept;
    logic   emit;
    logic   timeout_hit;

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: default assignment first so no path through this block can infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    next_state = in_last ? FULL : HALF;
                end
            end
            HALF: begin
                if (accept || timeout_hit) begin
                    next_state = FULL;
                end
            end
            FULL: begin
                if (emit) begin
                    if (accept) begin
                        next_state = in_last ? FULL : HALF;
                    end else begin
                        next_state = EMPTY;
                    end
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    // A full packer can still take a pair in the same cycle it drains (no bubble).
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        if (state == FULL) begin
            in_ready  = out_ready;
            out_valid = 1'b1;
        end
    end

    // Lane 0 load always starts a fresh packed word, so lane 1 is cleared alongside it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a0          <= '0;
            b0          <= '0;
            a1          <= '0;
            b1          <= '0;
            lane1_valid <= 1'b0;
        end else if (accept) begin
            if (state == HALF) begin
                a1          <= in_a;
                b1          <= in_b;
                lane1_valid <= 1'b1;
            end else begin
                a0          <= in_a;
                b0          <= in_b;
                a1          <= '0;
                b1          <= '0;
                lane1_valid <= 1'b0;
            end
        end
    end

`ifdef PACKER_TIMEOUT_EN
    localparam int unsigned cnt_w = (timeout > 1) ? $clog2(timeout + 1) : 1;

    logic [cnt_w-1:0] idle_cnt;

    assign timeout_hit = (state == HALF) && !accept && (idle_cnt == cnt_w'(timeout - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (next_state != HALF) begin
            idle_cnt <= '0;
        end else if (!accept) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_add_v2_packer.sv
// Directed self-checking bench for dsp_add_v2_packer (width 24, timeout 16).
// Expectations follow `define PACKER_TIMEOUT_EN when it is set for the build.
module tb_dsp_add_v2_packer;

    localparam int unsigned W = 24;

    logic         clock;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         lane1_valid;

    int checks = 0;
    int errors = 0;

    dsp_add_v2_packer #(.width(W), .timeout(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .a0         (a0),
        .b0         (b0),
        .a1         (a1),
        .b1         (b1),
        .lane1_valid(lane1_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock edge, then settle before inspecting registered outputs.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_last  = last;
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        #12;

        // Reset state
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_a0", 64'(a0), 64'd0);
        check("rst_lane1_valid", 64'(lane1_valid), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Two pairs complete one packed word
        drive(1'b1, 24'hFF, 24'h10, 1'b0);
        cyc();
        check("pair_half_out_valid", 64'(out_valid), 64'd0);
        drive(1'b1, 24'h17, 24'h07, 1'b0);
        cyc();
        check("pair_out_valid", 64'(out_valid), 64'd1);
        check("pair_a0", 64'(a0), 64'hFF);
        check("pair_b0", 64'(b0), 64'h10);
        check("pair_a1", 64'(a1), 64'h17);
        check("pair_b1", 64'(b1), 64'h07);
        check("pair_lane1_valid", 64'(lane1_valid), 64'd1);
        drive(1'b0, '0, '0, 1'b0);
        cyc();
        check("pair_emitted", 64'(out_valid), 64'd0);
        check("pair_hold_a1", 64'(a1), 64'h17);

        // in_last forces a single-lane emission
        drive(1'b1, 24'hFFFFFF, 24'h000010, 1'b1);
        cyc();
        check("last_out_valid", 64'(out_valid), 64'd1);
        check("last_a0", 64'(a0), 64'hFFFFFF);
        check("last_b0", 64'(b0), 64'h000010);
        check("last_a1", 64'(a1), 64'd0);
        check("last_b1", 64'(b1), 64'd0);
        check("last_lane1_valid", 64'(lane1_valid), 64'd0);
        drive(1'b0, '0, '0, 1'b0);
        cyc();
        check("last_emitted", 64'(out_valid), 64'd0);

        // Six back-to-back pairs -> three outputs in order
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, W'(24'h100 + i), W'(24'h200 + i), 1'b0);
            #1;
            check($sformatf("b2b_in_ready_%0d", i), 64'(in_ready), 64'd1);
            cyc();
            if (i % 2 == 1) begin
                check($sformatf("b2b_out_valid_%0d", i), 64'(out_valid), 64'd1);
                check($sformatf("b2b_a0_%0d", i), 64'(a0), 64'(24'h100 + i - 1));
                check($sformatf("b2b_b0_%0d", i), 64'(b0), 64'(24'h200 + i - 1));
                check($sformatf("b2b_a1_%0d", i), 64'(a1), 64'(24'h100 + i));
                check($sformatf("b2b_b1_%0d", i), 64'(b1), 64'(24'h200 + i));
            end else begin
                check($sformatf("b2b_out_valid_%0d", i), 64'(out_valid), 64'd0);
            end
        end
        drive(1'b0, '0, '0, 1'b0);
        cyc();
        check("b2b_drained", 64'(out_valid), 64'd0);

        // Backpressure holds lanes; release emits and accepts in one cycle
        out_ready = 1'b0;
        drive(1'b1, 24'hA1, 24'hB1, 1'b0);
        cyc();
        drive(1'b1, 24'hA2, 24'hB2, 1'b0);
        cyc();
        drive(1'b1, 24'hA3, 24'hB3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_in_ready_%0d", i), 64'(in_ready), 64'd0);
            check($sformatf("bp_out_valid_%0d", i), 64'(out_valid), 64'd1);
            check($sformatf("bp_a0_%0d", i), 64'(a0), 64'hA1);
            check($sformatf("bp_a1_%0d", i), 64'(a1), 64'hA2);
            check($sformatf("bp_b1_%0d", i), 64'(b1), 64'hB2);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        cyc();
        check("bp_after_out_valid", 64'(out_valid), 64'd0);
        check("bp_after_a0", 64'(a0), 64'hA3);
        check("bp_after_b0", 64'(b0), 64'hB3);
        check("bp_after_lane1_valid", 64'(lane1_valid), 64'd0);
        drive(1'b0, '0, '0, 1'b0);

        // Reset mid-cycle while HALF discards the held pair
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_a0", 64'(a0), 64'd0);
        check("rst_mid_b0", 64'(b0), 64'd0);
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        @(negedge clock);
        reset = 1'b0;
        drive(1'b1, 24'hC1, 24'hD1, 1'b0);
        cyc();
        check("post_rst_first_accept_a0", 64'(a0), 64'hC1);
        check("post_rst_no_emit", 64'(out_valid), 64'd0);
        drive(1'b1, 24'hC2, 24'hD2, 1'b0);
        cyc();
        check("post_rst_out_valid", 64'(out_valid), 64'd1);
        check("post_rst_a0", 64'(a0), 64'hC1);
        check("post_rst_a1", 64'(a1), 64'hC2);
        drive(1'b0, '0, '0, 1'b0);
        cyc();
        check("post_rst_drained", 64'(out_valid), 64'd0);

        // Lone pair then idle: timeout flush, or indefinite wait
        drive(1'b1, 24'hE1, 24'hF1, 1'b0);
        cyc();
        drive(1'b0, '0, '0, 1'b0);
`ifdef PACKER_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            cyc();
            check($sformatf("to_wait_%0d", i), 64'(out_valid), 64'd0);
        end
        cyc();
        check("to_out_valid", 64'(out_valid), 64'd1);
        check("to_a0", 64'(a0), 64'hE1);
        check("to_a1", 64'(a1), 64'd0);
        check("to_lane1_valid", 64'(lane1_valid), 64'd0);
        cyc();
        check("to_drained", 64'(out_valid), 64'd0);
`else
        for (int i = 1; i <= 100; i++) begin
            cyc();
            check($sformatf("no_to_wait_%0d", i), 64'(out_valid), 64'd0);
        end
        check("no_to_a0_held", 64'(a0), 64'hE1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_add_v2_packer.md
DSP_ADD_V2_PACKER -- requirements
Module: dsp_add_v2_packer

Interface
REQ-001 The module SHALL have parameter: width, 24, operand width per lane (1..24).
REQ-002 The module SHALL have parameter: timeout, 16, idle cycles before auto-flush of a half pair (used only with PACKER_TIMEOUT_EN).
REQ-003 The module SHALL have port: clock  input  1  sole clock, all state updates on rising edge.
REQ-004 The module SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 The module SHALL have port: in_valid  input  1  upstream operand pair valid.
REQ-006 The module SHALL have port: in_ready  output  1  packer can accept a pair this cycle.
REQ-007 The module SHALL have port: in_a  input  width  first operand.
REQ-008 The module SHALL have port: in_b  input  width  second operand.
REQ-009 The module SHALL have port: in_last  input  1  pair ends a burst; forces emission without waiting for a partner.
REQ-010 The module SHALL have port: out_valid  output  1  packed lanes valid toward dsp_add_v2.
REQ-011 The module SHALL have port: out_ready  input  1  downstream consumes packed lanes.
REQ-012 The module SHALL have port: a0, b0, a1, b1  output  width each  lane operands, registered.
REQ-013 The module SHALL have port: lane1_valid  output  1  lane 1 holds a real pair.

Function
REQ-014 The state machine SHALL have states EMPTY, HALF, FULL; transfer occurs on in_valid && in_ready (accept) or out_valid && out_ready (emit).
REQ-015 in_ready SHALL be 1 in EMPTY and HALF, and equal out_ready in FULL (combinational).
REQ-016 out_valid SHALL be 1 exactly when state is FULL.
REQ-017 EMPTY + accept SHALL load in_a/in_b into a0/b0; next state HALF, or FULL with lane1_valid=0 and a1=b1=0 if in_last.
REQ-018 HALF + accept SHALL load in_a/in_b into a1/b1, set lane1_valid=1, next state FULL (in_last irrelevant).
REQ-019 FULL + emit without accept SHALL go to EMPTY; lane registers SHALL hold their values.
REQ-020 FULL + emit + accept in the same cycle SHALL load the new pair into a0/b0 and proceed per REQ-017 (no bubble).
REQ-021 Lane registers SHALL be stable while out_valid && !out_ready.
REQ-022 Latency: a completing pair accepted at edge k SHALL produce out_valid=1 immediately after edge k; sustained throughput one packed output per two accepts.
REQ-023 Pair ordering SHALL be preserved: first accepted pair always in lane 0.
REQ-024 Operands SHALL pass unmodified, no arithmetic, full width.

Reset
REQ-025 Reset assertion SHALL immediately force state EMPTY, out_valid=0, lane1_valid=0, a0=b0=a1=b1=0, idle counter 0, regardless of operation in progress.
REQ-026 A half pair held at reset assertion SHALL be discarded; in_ready SHALL be 1 during reset.
REQ-027 The first accept SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-028 With macro PACKER_TIMEOUT_EN defined, an idle counter SHALL count cycles in HALF without accept; on reaching timeout the block SHALL go FULL with lane1_valid=0, a1=b1=0; counter clears on leaving HALF.
REQ-029 Without PACKER_TIMEOUT_EN, no counter SHALL be built and HALF SHALL wait indefinitely for a partner or reset.

Verification
REQ-030 Accept (8'hFF,8'h10) then (8'h17,8'h07), out_ready=1, width=8 -> one output a0=FF b0=10 a1=17 b1=07 lane1_valid=1 one cycle after second accept.
REQ-031 Single pair (24'hFFFFFF,24'h000010) with in_last=1 -> out_valid next cycle, lane1_valid=0, a1=b1=0.
REQ-032 Six back-to-back pairs, out_ready=1 -> three outputs, in_ready never low, order preserved.
REQ-033 out_ready=0 for 4 cycles while FULL -> in_ready=0, lanes unchanged; release -> emit once, next pair accepted same cycle.
REQ-034 Reset asserted mid-cycle while HALF -> outputs zero immediately, no emission of the held pair after release.
REQ-035 With PACKER_TIMEOUT_EN, timeout=16: one pair then idle -> out_valid rises after 16 idle cycles with lane1_valid=0; without macro, out_valid stays 0 for 100 cycles.
